pdh_cmd_dispatch: RTL

PDH_CMD_DISPATCH -- requirements
Module: pdh_cmd_dispatch

---
 rtl/pdh_cmd_pkg.sv | 27 ++
 rtl/pdh_cmd_dispatch_if.sv | 38 +++
 rtl/pdh_cycle_timer.sv | 39 +++
 rtl/pdh_cmd_dispatch.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/pdh_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pdh_cmd_pkg
//  Description : Shared types and defaults for the PDH command dispatcher:
//                FSM state encoding, default phase lengths, and a small
//                helper used to size the phase counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package pdh_cmd_pkg;

    // Dispatcher phases: wait for host, clear the unit, run the unit, present result.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_ARM   = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int DEF_CLR_CYCLES    = 2;
    localparam int DEF_SETTLE_CYCLES = 5;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : pdh_cmd_pkg
`default_nettype wire

// File: rtl/pdh_cmd_dispatch_if.sv
`default_nettype none
// ============================================================================
//  Module      : pdh_cmd_dispatch_if
//  Description : Bundle of the host command/response handshake and the
//                functional-unit control/callback signals. Signal suffixes
//                are from the dispatcher's point of view.
//                slave  : dispatcher side
//                master : host + functional-unit side (bench / integrator)
//  Revision    : 1.0 - initial release
// ============================================================================
interface pdh_cmd_dispatch_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int CALLBACK_WIDTH = 8
);
    logic                      cmd_valid_i;
    logic                      cmd_ready_o;
    logic [DATA_WIDTH-1:0]     cmd_data_i;
    logic                      en_o;
    logic                      clr_o;
    logic [DATA_WIDTH-1:0]     data_o;
    logic [CALLBACK_WIDTH-1:0] callback_i;
    logic                      rsp_valid_o;
    logic                      rsp_ready_i;
    logic [CALLBACK_WIDTH-1:0] rsp_data_o;
    logic                      rsp_err_o;

    modport slave (
        input  cmd_valid_i, cmd_data_i, callback_i, rsp_ready_i,
        output cmd_ready_o, en_o, clr_o, data_o, rsp_valid_o, rsp_data_o, rsp_err_o
    );

    modport master (
        output cmd_valid_i, cmd_data_i, callback_i, rsp_ready_i,
        input  cmd_ready_o, en_o, clr_o, data_o, rsp_valid_o, rsp_data_o, rsp_err_o
    );

endinterface : pdh_cmd_dispatch_if
`default_nettype wire

// File: rtl/pdh_cycle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : pdh_cycle_timer
//  Description : Loadable saturating down-counter. done_o is high during the
//                final cycle of a loaded interval (count == 1), so a load of
//                N yields exactly N cycles with done_o on the last one.
//  Ports       : clk, rst_n      - clock, synchronous active-low reset
//                load_i          - load load_val_i (takes priority)
//                load_val_i      - interval length in cycles (>= 1)
//                done_o          - last-cycle-of-interval pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module pdh_cycle_timer #(
    parameter int CNT_W = 3
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             load_i,
    input  wire logic [CNT_W-1:0] load_val_i,
    output logic                  done_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            // Saturate at zero so an idle timer never wraps into a false done.
            count_q <= count_q - 1'b1;
        end
    end

    assign done_o = (count_q == CNT_W'(1));

endmodule : pdh_cycle_timer
`default_nettype wire

// File: rtl/pdh_cmd_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : pdh_cmd_dispatch
//  Description : Single-outstanding command dispatcher. Accepts a payload
//                from the host, pulses clr_o for CLR_CYCLES, holds en_o for
//                SETTLE_CYCLES, samples the unit's callback word on the last
//                enable cycle and presents it (with an echo-mismatch flag)
//                until the host takes it. All outputs are registered.
//  Ports       : clk, rst_n  - clock, synchronous active-low reset
//                bus (slave) - cmd_valid_i/cmd_ready_o/cmd_data_i host command,
//                              en_o/clr_o/data_o/callback_i functional unit,
//                              rsp_valid_o/rsp_ready_i/rsp_data_o/rsp_err_o
//                              host response
//  Revision    : 1.0 - initial release
// ============================================================================
module pdh_cmd_dispatch
    import pdh_cmd_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int CALLBACK_WIDTH = 8,
    parameter int CLR_CYCLES     = DEF_CLR_CYCLES,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int CHECK_ECHO     = 1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    pdh_cmd_dispatch_if.slave bus
);

    localparam int CNT_W = $clog2(max_int(CLR_CYCLES, SETTLE_CYCLES) + 1);

    state_t                    state_q, state_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic [CALLBACK_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                      rsp_err_q, rsp_err_d;
    logic                      cmd_ready_q, cmd_ready_d;
    logic                      clr_q, clr_d;
    logic                      en_q, en_d;
    logic                      rsp_valid_q, rsp_valid_d;

    logic                      tmr_load;
    logic [CNT_W-1:0]          tmr_load_val;
    logic                      tmr_done;
    logic [CALLBACK_WIDTH-1:0] cmp_payload;

    // Payload as seen by the echo compare: truncated or zero-extended.
    generate
        if (DATA_WIDTH >= CALLBACK_WIDTH) begin : g_cmp_trunc
            assign cmp_payload = data_q[CALLBACK_WIDTH-1:0];
        end else begin : g_cmp_zext
            assign cmp_payload = {{(CALLBACK_WIDTH-DATA_WIDTH){1'b0}}, data_q};
        end
    endgenerate

    pdh_cycle_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .done_o     (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            clr_q       <= 1'b0;
            en_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            cmd_ready_q <= cmd_ready_d;
            clr_q       <= clr_d;
            en_q        <= en_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid_i) begin
                    data_d       = bus.cmd_data_i;
                    state_d      = ST_CLEAR;
                    tmr_load     = 1'b1;
                    tmr_load_val = CNT_W'(CLR_CYCLES);
                end
            end
            ST_CLEAR: begin
                if (tmr_done) begin
                    state_d      = ST_ARM;
                    tmr_load     = 1'b1;
                    tmr_load_val = CNT_W'(SETTLE_CYCLES);
                end
            end
            ST_ARM: begin
                if (tmr_done) begin
                    state_d    = ST_RESP;
                    rsp_data_d = bus.callback_i;
                    rsp_err_d  = (CHECK_ECHO != 0) && (bus.callback_i != cmp_payload);
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they register in
        // lock-step with the state: en_o rises on the same edge clr_o falls.
        cmd_ready_d = (state_d == ST_IDLE);
        clr_d       = (state_d == ST_CLEAR);
        en_d        = (state_d == ST_ARM);
        rsp_valid_d = (state_d == ST_RESP);
    end

    assign bus.cmd_ready_o = cmd_ready_q;
    assign bus.clr_o       = clr_q;
    assign bus.en_o        = en_q;
    assign bus.data_o      = data_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_data_o  = rsp_data_q;
    assign bus.rsp_err_o   = rsp_err_q;

endmodule : pdh_cmd_dispatch
`default_nettype wire
